// File: rtl/rs_pkg.sv
// Shared constants and helpers for the RS(15,11) datapath over GF(16), field poly x^4+x+1.
// Generator coefficients G are listed from x^3 down to x^0 (g(x) is monic).
package rs_pkg;

  localparam int SYM_W = 4;
  localparam int K     = 11;
  localparam int NPAR  = 4;

  // x^4 reduces to x+1
  localparam logic [3:0] PRIM_RED = 4'h3;

  localparam logic [3:0] G [0:3] = '{4'hD, 4'hC, 4'h8, 4'h7};

  typedef enum logic {MSG = 1'b0, PARITY = 1'b1} state_e;

  // Multiply a field element by alpha (x), reducing modulo the primitive polynomial.
  function automatic logic [3:0] gf_xtime(input logic [3:0] a);
    gf_xtime = {a[2:0], 1'b0} ^ (a[3] ? PRIM_RED : 4'h0);
  endfunction

endpackage

// File: rtl/gf16_cmul.sv
// Combinational GF(16) multiply of a symbol by a constant; one instance per LFSR tap.
module gf16_cmul #(
  parameter logic [3:0] C = 4'h1
) (
  input  logic [3:0] a_i,
  output logic [3:0] p_o
);
  import rs_pkg::*;

  logic [3:0] acc;
  logic [3:0] pw;

  // Shift-and-add: accumulate a*x^b for every set bit b of the constant.
  always_comb begin
    acc = 4'h0;
    pw  = a_i;
    for (int b = 0; b < 4; b++) begin
      if (C[b]) acc = acc ^ pw;
      pw = gf_xtime(pw);
    end
  end

  assign p_o = acc;

endmodule

// File: rtl/rs_encoder_15_11.sv
// Systematic RS(15,11) encoder: echoes K message symbols, then shifts out 4 parity symbols.
// Define RS_ENC_SHORTEN_EN to let in_last end a message early (shortened codewords).
module rs_encoder_15_11 #(
  parameter int SYM_W = 4,
  parameter int K     = 11,
  parameter int NPAR  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  output logic [SYM_W-1:0] out_sym,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_par,
  output logic             out_last
);
  import rs_pkg::*;

  if (SYM_W != 4) begin : g_bad_sym_w
    $error("rs_encoder_15_11: SYM_W must be 4");
  end

  state_e     state_q, state_d;
  logic [3:0] sym_cnt_q, sym_cnt_d;
  logic [3:0] p0_q, p1_q, p2_q, p3_q;
  logic [3:0] p0_d, p1_d, p2_d, p3_d;
  logic [3:0] out_sym_q, out_sym_d;
  logic       out_valid_q, out_valid_d;
  logic       out_par_q, out_par_d;
  logic       out_last_q, out_last_d;

  logic       adv;
  logic       accept;
  logic       msg_end;
  logic [3:0] fb;
  logic [3:0] m3, m2, m1, m0;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = RESET && (state_q == MSG) && adv;
  assign accept   = in_valid && in_ready;
  assign fb       = in_sym ^ p3_q;

`ifdef RS_ENC_SHORTEN_EN
  assign msg_end = (sym_cnt_q == 4'(K - 1)) || in_last;
`else
  assign msg_end = (sym_cnt_q == 4'(K - 1));
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  gf16_cmul #(.C(G[0])) u_tap3 (.a_i(fb), .p_o(m3));
  gf16_cmul #(.C(G[1])) u_tap2 (.a_i(fb), .p_o(m2));
  gf16_cmul #(.C(G[2])) u_tap1 (.a_i(fb), .p_o(m1));
  gf16_cmul #(.C(G[3])) u_tap0 (.a_i(fb), .p_o(m0));

  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;
    out_sym_d   = out_sym_q;
    out_valid_d = out_valid_q;
    out_par_d   = out_par_q;
    out_last_d  = out_last_q;

    if (state_q == MSG) begin
      if (accept) begin
        out_sym_d   = in_sym;
        out_valid_d = 1'b1;
        out_par_d   = 1'b0;
        out_last_d  = 1'b0;
        p3_d        = p2_q ^ m3;
        p2_d        = p1_q ^ m2;
        p1_d        = p0_q ^ m1;
        p0_d        = m0;
        if (msg_end) begin
          state_d   = PARITY;
          sym_cnt_d = 4'h0;
        end else begin
          sym_cnt_d = sym_cnt_q + 4'h1;
        end
      end else if (adv) begin
        out_valid_d = 1'b0;
      end
    end else if (adv) begin
      // Parity phase: the remainder drains out of p3, zeros shift in behind it.
      out_sym_d   = p3_q;
      out_valid_d = 1'b1;
      out_par_d   = 1'b1;
      out_last_d  = 1'b0;
      p3_d        = p2_q;
      p2_d        = p1_q;
      p1_d        = p0_q;
      p0_d        = 4'h0;
      if (sym_cnt_q == 4'(NPAR - 1)) begin
        out_last_d = 1'b1;
        state_d    = MSG;
        sym_cnt_d  = 4'h0;
      end else begin
        sym_cnt_d = sym_cnt_q + 4'h1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= MSG;
      sym_cnt_q   <= 4'h0;
      p0_q        <= 4'h0;
      p1_q        <= 4'h0;
      p2_q        <= 4'h0;
      p3_q        <= 4'h0;
      out_sym_q   <= 4'h0;
      out_valid_q <= 1'b0;
      out_par_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      out_sym_q   <= out_sym_d;
      out_valid_q <= out_valid_d;
      out_par_q   <= out_par_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_sym   = out_sym_q;
  assign out_valid = out_valid_q;
  assign out_par   = out_par_q;
  assign out_last  = out_last_q;

endmodule
